activation_skew_feeder: RTL and testbench

ACTIVATION_SKEW_FEEDER -- requirements
Module: activation_skew_feeder

---
 rtl/activation_skew_feeder.sv | 160 ++++++++++++++++
 tb/tb_activation_skew_feeder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_skew_feeder.sv
// Buffers activation vectors in a small FIFO and feeds them to a MAC matrix with
// lane i delayed by i cycles, closing each batch with a drain phase and a done pulse.
module activation_skew_feeder #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned MAC_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MAC_WIDTH*DATA_SIZE-1:0] in_data,
    input  logic                           in_last,
    output logic [MAC_WIDTH*DATA_SIZE-1:0] out_values,
    output logic [MAC_WIDTH-1:0]           out_lane_valid,
    output logic                           busy,
    output logic                           drain_done
);

    localparam int unsigned VEC_W      = MAC_WIDTH * DATA_SIZE;
    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DRN_W      = (MAC_WIDTH > 1) ? $clog2(MAC_WIDTH) : 1;
    localparam int unsigned DRAIN_LOAD = (MAC_WIDTH > 1) ? MAC_WIDTH - 2 : 0;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic               drain_done_q, drain_done_d;
    logic               last_pend_q, last_pend_d;

    logic [VEC_W:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [VEC_W:0]     head;
    logic               push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Once a last-flagged vector is taken, nothing more enters until the batch closes.
    assign in_ready = !reset && (count_q < CNT_W'(FIFO_DEPTH)) && (state_q != DRAIN) && !last_pend_q;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == STREAM) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            drn_q        <= '0;
            drain_done_q <= 1'b0;
            last_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            drn_q        <= drn_d;
            drain_done_q <= drain_done_d;
            last_pend_q  <= last_pend_d;
        end
    end

    // Batch sequencing: stream pops, then wait for the last vector to clear the skew.
    always_comb begin
        state_d      = state_q;
        drn_d        = drn_q;
        drain_done_d = 1'b0;
        last_pend_d  = last_pend_q;
        if (push && in_last) begin
            last_pend_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (pop && head[VEC_W]) begin
                    if (MAC_WIDTH == 1) begin
                        state_d      = IDLE;
                        drain_done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        drn_d   = DRN_W'(DRAIN_LOAD);
                    end
                end
            end
            DRAIN: begin
                if (drn_q == '0) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == IDLE) begin
            last_pend_d = 1'b0;
        end
    end

    // Lane i owns i+1 registers; bubbles carry zero data so idle lanes read 0.
    for (genvar i = 0; i < MAC_WIDTH; i++) begin : g_lane
        logic [DATA_SIZE-1:0] dat_q [i+1];
        logic                 vld_q [i+1];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int j = 0; j <= i; j++) begin
                    dat_q[j] <= '0;
                    vld_q[j] <= 1'b0;
                end
            end else begin
                dat_q[0] <= pop ? head[i*DATA_SIZE +: DATA_SIZE] : '0;
                vld_q[0] <= pop;
                for (int j = 1; j <= i; j++) begin
                    dat_q[j] <= dat_q[j-1];
                    vld_q[j] <= vld_q[j-1];
                end
            end
        end

        assign out_values[i*DATA_SIZE +: DATA_SIZE] = dat_q[i];
        assign out_lane_valid[i]                    = vld_q[i];
    end

    assign busy       = (state_q != IDLE) || (count_q != '0) || (|out_lane_valid);
    assign drain_done = drain_done_q;

endmodule

// File: tb/tb_activation_skew_feeder.sv
// Scoreboard bench for activation_skew_feeder: expected lane values, lane timing,
// drain pulses, busy and in_ready are derived from vector arrival times.
module tb_activation_skew_feeder;

    localparam int DW = 8;
    localparam int MW = 8;
    localparam int FD = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [MW*DW-1:0] in_data;
    logic             in_last;
    logic [MW*DW-1:0] out_values;
    logic [MW-1:0]    out_lane_valid;
    logic             busy;
    logic             drain_done;

    activation_skew_feeder #(
        .DATA_SIZE (DW),
        .MAC_WIDTH (MW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_values    (out_values),
        .out_lane_valid(out_lane_valid),
        .busy          (busy),
        .drain_done    (drain_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] v;
        longint        t;
    } item_t;

    longint cyc = 0;
    item_t  lane_q [MW][$];
    longint dd_q[$];
    longint pop_q[$];
    longint last_pop = -100;
    bit     batch_open = 0;
    bit     last_pending = 0;
    int     errors = 0;
    int     checks = 0;
    int     lasts_acc = 0;
    int     dd_seen = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic bit lanes_pending();
        for (int i = 0; i < MW; i++) begin
            if (lane_q[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Monitor: in the cycle after edge e, compare what the DUT presents with the model.
    always @(negedge clock) begin
        longint        e;
        longint        p;
        logic [DW-1:0] v;
        item_t         it;
        e = cyc;
        for (int i = 0; i < MW; i++) begin
            v = out_values[i*DW +: DW];
            if (out_lane_valid[i]) begin
                if (lane_q[i].size() == 0) begin
                    chk($sformatf("lane%0d_unexpected_valid", i), 1, 0);
                end else begin
                    it = lane_q[i].pop_front();
                    chk($sformatf("lane%0d_value", i), v, it.v);
                    chk($sformatf("lane%0d_time", i), e, it.t);
                end
            end else begin
                chk($sformatf("lane%0d_bubble_value", i), v, 0);
                if (lane_q[i].size() != 0 && lane_q[i][0].t <= e) begin
                    chk($sformatf("lane%0d_missing_valid", i), e, lane_q[i][0].t);
                    void'(lane_q[i].pop_front());
                end
            end
        end
        if (drain_done) begin
            dd_seen++;
            if (dd_q.size() == 0) chk("drain_done_unexpected", 1, 0);
            else chk("drain_done_time", e, dd_q.pop_front());
        end else if (dd_q.size() != 0 && dd_q[0] <= e) begin
            chk("drain_done_missing", e, dd_q[0]);
            void'(dd_q.pop_front());
        end
        while (pop_q.size() != 0 && pop_q[0] <= e) void'(pop_q.pop_front());
        chk("busy", busy, longint'(batch_open || lanes_pending()));
        if (!drain_done) begin
            chk("in_ready", in_ready, longint'(!reset && !last_pending && pop_q.size() < FD));
        end
        if (drain_done) begin
            batch_open   = 0;
            last_pending = 0;
        end
        // Acceptance at edge e+1; pops run one per cycle once streaming.
        if (in_valid && in_ready && !reset) begin
            p = (e + 2 > last_pop + 1) ? e + 2 : last_pop + 1;
            last_pop = p;
            pop_q.push_back(p);
            for (int i = 0; i < MW; i++) begin
                it.v = in_data[i*DW +: DW];
                it.t = p + i;
                lane_q[i].push_back(it);
            end
            if (in_last) begin
                dd_q.push_back(p + MW - 1);
                last_pending = 1;
                lasts_acc++;
            end
            batch_open = 1;
        end
        if (reset) begin
            for (int i = 0; i < MW; i++) lane_q[i].delete();
            dd_q.delete();
            pop_q.delete();
            last_pop     = -100;
            batch_open   = 0;
            last_pending = 0;
        end
    end

    task automatic send(input logic [MW*DW-1:0] d, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((batch_open || lanes_pending()) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        #1;
        if (n >= 3000) chk("idle_timeout", 0, 1);
        idle(2);
    endtask

    function automatic logic [MW*DW-1:0] rep(input logic [DW-1:0] b);
        return {MW{b}};
    endfunction

    function automatic logic [MW*DW-1:0] ramp(input logic [DW-1:0] b);
        logic [MW*DW-1:0] r;
        for (int i = 0; i < MW; i++) r[i*DW +: DW] = b + DW'(i);
        return r;
    endfunction

    function automatic logic [MW*DW-1:0] rnd_vec();
        logic [MW*DW-1:0] r;
        for (int i = 0; i < MW; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    initial begin
        bit last;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        idle(3);
        reset = 1'b0;

        send(ramp(8'h10), 1'b1);
        wait_idle();

        send(rep(8'hA1), 1'b0);
        send(rep(8'hB2), 1'b0);
        send(rep(8'hC3), 1'b1);
        wait_idle();

        send(rep(8'h01), 1'b0);
        idle(2);
        send(rep(8'h02), 1'b1);
        wait_idle();

        for (int k = 0; k < 5; k++) send(ramp(8'(8'h40 + 16 * k)), k == 4);
        wait_idle();

        send(rep(8'h55), 1'b0);
        send(rep(8'h66), 1'b0);
        send(rep(8'h77), 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(2);
        send(ramp(8'h10), 1'b1);
        wait_idle();

        lasts_acc = 0;
        dd_seen   = 0;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            last = (k == 199) || ($urandom_range(0, 7) == 0);
            send(rnd_vec(), last);
        end
        wait_idle();
        chk("drain_count", dd_seen, lasts_acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
